// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage dcache access controller with LR/SC reservation
module mem_access_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LINK_LSB = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              lr_i,
    input  logic              sc_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dmemload,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              dhit_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              sc_result_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic              rd_q, rd_d, wr_q, wr_d, sc_q, sc_d, lr_q, lr_d;
    logic              link_valid_q, link_valid_d;
    logic [ADDR_W-1:0] link_addr_q, link_addr_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic              sc_result_q, sc_result_d;

    // Addresses match when they agree in every bit at or above LINK_LSB.
    function automatic logic line_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return ((a ^ b) >> LINK_LSB) == '0;
    endfunction

    logic op, is_rd, is_wr, sc_ok, sc_fail;
    logic c_rd, c_wr, c_sc, c_lr, done;

    assign op      = (mem_read_i | mem_write_i) & ~flush;
    assign is_rd   = mem_read_i;
    assign is_wr   = mem_write_i & ~mem_read_i;
    assign sc_ok   = link_valid_q & line_match(link_addr_q, addr_i);
    assign sc_fail = op & is_wr & sc_i & ~sc_ok;

    assign dmemaddr    = addr_i;
    assign dmemstore   = wdata_i;
    assign load_data_o = load_data_q;
    assign sc_result_o = sc_result_q;

    // Next state, request/stall/hit outputs, result capture and reservation update.
    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        sc_d         = sc_q;
        lr_d         = lr_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        load_data_d  = load_data_q;
        sc_result_d  = sc_result_q;
        dmemREN      = 1'b0;
        dmemWEN      = 1'b0;
        mem_stall    = 1'b0;
        dhit_o       = 1'b0;
        done         = 1'b0;
        // In IDLE the access kind comes from the latch; once issued it is frozen.
        c_rd = (state_q == IDLE) ? is_rd : rd_q;
        c_wr = (state_q == IDLE) ? is_wr : wr_q;
        c_sc = (state_q == IDLE) ? (sc_i & is_wr) : sc_q;
        c_lr = (state_q == IDLE) ? (lr_i & is_rd) : lr_q;

        // Requests are dropped while reset is held, even if the latch still presents an op.
        if (nRST) begin
            case (state_q)
                IDLE: begin
                    if (sc_fail) begin
                        dhit_o       = 1'b1;
                        sc_result_d  = 1'b1;
                        link_valid_d = 1'b0;
                        state_d      = en ? IDLE : DONE;
                    end else if (op) begin
                        dmemREN = is_rd;
                        dmemWEN = is_wr;
                        rd_d    = is_rd;
                        wr_d    = is_wr;
                        sc_d    = sc_i & is_wr;
                        lr_d    = lr_i & is_rd;
                        if (dhit) begin
                            done    = 1'b1;
                            state_d = en ? IDLE : DONE;
                        end else begin
                            mem_stall = 1'b1;
                            state_d   = BUSY;
                        end
                    end
                end
                BUSY: begin
                    dmemREN = rd_q;
                    dmemWEN = wr_q;
                    if (dhit) begin
                        done    = 1'b1;
                        state_d = en ? IDLE : DONE;
                    end else begin
                        mem_stall = 1'b1;
                    end
                end
                DONE: begin
                    if (en) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            if (done) begin
                dhit_o      = 1'b1;
                sc_result_d = 1'b0;
                if (c_rd) load_data_d = dmemload;
                if (c_lr) begin
                    link_valid_d = 1'b1;
                    link_addr_d  = addr_i;
                end else if (c_sc) begin
                    link_valid_d = 1'b0;
                end else if (c_wr && line_match(link_addr_q, addr_i)) begin
                    link_valid_d = 1'b0;
                end
            end

            // A snoop overrides a reservation being set in the same cycle.
            if (snoop_inv && line_match(snoop_addr, link_addr_d)) link_valid_d = 1'b0;
        end
    end

    // State and captured results; asynchronous reset drops everything.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            sc_q         <= 1'b0;
            lr_q         <= 1'b0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            load_data_q  <= '0;
            sc_result_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            sc_q         <= sc_d;
            lr_q         <= lr_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            load_data_q  <= load_data_d;
            sc_result_q  <= sc_result_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized transaction-level check of mem_access_ctrl
module tb_mem_access_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        en, flush, mem_read_i, mem_write_i, lr_i, sc_i, dhit, snoop_inv;
    logic [31:0] addr_i, wdata_i, dmemload, snoop_addr;
    logic        dmemREN, dmemWEN, mem_stall, dhit_o, sc_result_o;
    logic [31:0] dmemaddr, dmemstore, load_data_o;

    always #5 CLK = ~CLK;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .LINK_LSB(2)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .lr_i(lr_i), .sc_i(sc_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .dhit(dhit), .dmemload(dmemload),
        .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .dhit_o(dhit_o), .load_data_o(load_data_o), .sc_result_o(sc_result_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: reservation, last load result, last SC result.
    bit          m_lv = 0;
    logic [31:0] m_la = '0;
    logic [31:0] m_ld = '0;
    bit          m_sc = 0;

    localparam int K_LW = 0, K_SW = 1, K_LR = 2, K_SC = 3, K_RW = 4, K_FL = 5;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
        return (a >> 2) == (b >> 2);
    endfunction

    task automatic drive_idle();
        en = 1'b1; flush = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        lr_i = 1'b0; sc_i = 1'b0; dhit = 1'b0; snoop_inv = 1'b0;
        addr_i = '0; wdata_i = '0; dmemload = '0; snoop_addr = '0;
    endtask

    // One pipeline operation: dhit after lat cycles, then hold cycles with en low.
    task automatic txn(input int kind, input logic [31:0] a, input logic [31:0] wd,
                       input int lat, input int hold, input bit sn, input int s_in,
                       input logic [31:0] sa, input string tag);
        logic [31:0] ld_val = $urandom;
        bit is_rd   = (kind == K_LW) || (kind == K_LR) || (kind == K_RW);
        bit is_wr   = (kind == K_SW) || (kind == K_SC);
        bit flushed = (kind == K_FL);
        bit fail    = (kind == K_SC) && !(m_lv && same_line(m_la, a));
        int span    = (fail || flushed) ? 1 : lat + 1;
        int total   = flushed ? 1 : span + hold;
        int s       = s_in % span;
        int ren_n = 0, wen_n = 0, stall_n = 0, hit_n = 0, hit_at = -1;
        bit bus_ok  = 1;
        for (int k = 0; k < total; k++) begin
            @(posedge CLK); #1;
            mem_read_i  = is_rd || flushed;
            mem_write_i = is_wr || (kind == K_RW);
            lr_i        = (kind == K_LR);
            sc_i        = (kind == K_SC);
            flush       = flushed;
            addr_i      = a;
            wdata_i     = wd;
            dhit        = !fail && !flushed && (k == lat);
            dmemload    = (k == lat) ? ld_val : $urandom;
            en          = (k == total - 1);
            snoop_inv   = sn && (k == s);
            snoop_addr  = sa;
            @(negedge CLK);
            ren_n   += dmemREN;
            wen_n   += dmemWEN;
            stall_n += mem_stall;
            hit_n   += dhit_o;
            if (dhit_o) hit_at = k;
            if ((dmemREN || dmemWEN) && (dmemaddr !== a)) bus_ok = 0;
            if (dmemWEN && (dmemstore !== wd)) bus_ok = 0;
        end
        @(posedge CLK); #1;
        drive_idle();

        if (flushed) begin
            check({tag, " ren"}, ren_n, 0);
            check({tag, " wen"}, wen_n, 0);
            check({tag, " hits"}, hit_n, 0);
            if (sn && m_lv && same_line(sa, m_la)) m_lv = 0;
        end else if (fail) begin
            check({tag, " ren"}, ren_n, 0);
            check({tag, " wen"}, wen_n, 0);
            check({tag, " hit_at"}, hit_at, 0);
            m_sc = 1;
            m_lv = 0;
        end else begin
            check({tag, " ren"}, ren_n, is_rd ? lat + 1 : 0);
            check({tag, " wen"}, wen_n, is_wr ? lat + 1 : 0);
            check({tag, " stall"}, stall_n, lat);
            check({tag, " hit_at"}, hit_at, lat);
            m_sc = 0;
            if (is_rd) m_ld = ld_val;
            if (kind == K_LR) begin
                m_lv = 1;
                m_la = a;
                if (sn && s == lat && same_line(sa, a)) m_lv = 0;
            end else begin
                if (kind == K_SC) m_lv = 0;
                if (kind == K_SW && same_line(m_la, a)) m_lv = 0;
                if (sn && m_lv && same_line(sa, m_la)) m_lv = 0;
            end
        end
        check({tag, " hit_count"}, hit_n, (flushed ? 0 : 1));
        check({tag, " bus"}, bus_ok, 1);
        check({tag, " load_data"}, load_data_o, m_ld);
        check({tag, " sc_result"}, sc_result_o, m_sc);
    endtask

    // Idle pipeline cycle, optionally carrying a snoop.
    task automatic gap(input bit sn, input logic [31:0] sa);
        @(posedge CLK); #1;
        drive_idle();
        snoop_inv  = sn;
        snoop_addr = sa;
        if (sn && m_lv && same_line(sa, m_la)) m_lv = 0;
        @(posedge CLK); #1;
        drive_idle();
    endtask

    logic [31:0] pool [4];

    initial begin
        pool[0] = 32'h200; pool[1] = 32'h202; pool[2] = 32'h204; pool[3] = 32'h300;
        drive_idle();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset ren", dmemREN, 0);
        check("reset wen", dmemWEN, 0);
        check("reset stall", mem_stall, 0);
        check("reset hit", dhit_o, 0);
        check("reset load_data", load_data_o, 0);
        check("reset sc_result", sc_result_o, 0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        txn(K_LW, 32'h100, 0, 2, 0, 0, 0, 0, "lw_wait2");
        txn(K_SW, 32'h180, 32'hdead_beef, 1, 3, 0, 0, 0, "sw_held");
        txn(K_LR, 32'h200, 0, 1, 0, 0, 0, 0, "lr_a");
        txn(K_SC, 32'h200, 32'h1111, 1, 0, 0, 0, 0, "sc_pass");
        txn(K_SC, 32'h200, 32'h2222, 0, 0, 0, 0, 0, "sc_after_sc");
        txn(K_LR, 32'h200, 0, 0, 0, 0, 0, 0, "lr_b");
        gap(1, 32'h202);
        txn(K_SC, 32'h200, 32'h3333, 0, 1, 0, 0, 0, "sc_snooped");
        txn(K_LR, 32'h200, 0, 0, 0, 0, 0, 0, "lr_c");
        txn(K_SC, 32'h300, 32'h4444, 0, 0, 0, 0, 0, "sc_other_addr");
        txn(K_FL, 32'h100, 0, 0, 0, 0, 0, 0, "flush_lw");
        txn(K_LR, 32'h200, 0, 0, 0, 0, 0, 0, "lr_d");
        txn(K_SC, 32'h200, 32'h5555, 2, 0, 1, 1, 32'h200, "sc_snoop_busy");
        txn(K_LR, 32'h200, 0, 1, 0, 1, 1, 32'h200, "lr_snoop_same");
        txn(K_SC, 32'h200, 32'h6666, 0, 0, 0, 0, 0, "sc_after_lr_snoop");
        txn(K_RW, 32'h140, 32'h7777, 1, 1, 0, 0, 0, "rw_read_wins");

        for (int i = 0; i < 150; i++) begin
            txn($urandom_range(0, 5), pool[$urandom_range(0, 3)], $urandom,
                $urandom_range(0, 3), $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 3), pool[$urandom_range(0, 3)], "rnd");
            if ($urandom_range(0, 3) == 0) gap(1, pool[$urandom_range(0, 3)]);
        end

        // Reset in the middle of a pending load: request drops, reservation is lost.
        txn(K_LR, 32'h200, 0, 0, 0, 0, 0, 0, "lr_pre_reset");
        @(posedge CLK); #1;
        mem_read_i = 1'b1; addr_i = 32'h100; en = 1'b0; dhit = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("busy ren", dmemREN, 1);
        check("busy stall", mem_stall, 1);
        #1 nRST = 1'b0;
        #1;
        check("nrst ren", dmemREN, 0);
        check("nrst stall", mem_stall, 0);
        check("nrst load_data", load_data_o, 0);
        @(posedge CLK); #1;
        drive_idle();
        nRST = 1'b1;
        m_lv = 0; m_ld = '0; m_sc = 0;
        txn(K_SC, 32'h200, 32'h8888, 0, 0, 0, 0, 0, "sc_after_reset");
        txn(K_LW, 32'h104, 0, 0, 0, 0, 0, 0, "lw_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
